// File: rtl/clock_period_monitor_if.sv
// Measurement bus of clock_period_monitor: monitored signal in, period/high-time results
// and error flags out.
interface clock_period_monitor_if #(
  parameter int CNT_W = 16
);
  logic             mon_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             period_err;
  logic             duty_err;
  logic             timeout;

  modport master (
    input  mon_in,
    output period, high_time, meas_valid, period_err, duty_err, timeout
  );

  modport slave (
    output mon_in,
    input  period, high_time, meas_valid, period_err, duty_err, timeout
  );
endinterface

// File: rtl/clock_period_monitor.sv
// Measures period and high time of a slow divided clock sampled on clk_in, with period,
// duty and stuck-signal checks. Define DUTY_CHECK_EN to build the duty comparator.
module clock_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1
)(
  input  logic                   clk_in,
  input  logic                   rst,
  clock_period_monitor_if.master bus
);
  localparam int               AW      = CNT_W + 2;
  localparam int               STAGES  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0]    EXP_A   = AW'(EXP_PERIOD);
  localparam logic [AW-1:0]    TOL_A   = AW'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

  state_e           state, state_nxt;
  logic [2:0]       sync_q;            // [0]/[1] synchronizer, [2] edge-detect register
  logic [STAGES:0]  vld_pipe;          // marks synchronizer stages holding post-reset samples
  logic [CNT_W-1:0] cnt, hi_cap;
  logic [CNT_W-1:0] period_q, high_q;
  logic             meas_valid_q, perr_q, derr_q, timeout_q;
  logic             rise, fall, sat;
  logic             meas_fire, cap_hi, to_fire;
  logic [AW-1:0]    per_a, pdiff;
  logic             perr_nxt, derr_nxt;

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
  assign sat  = (cnt == CNT_MAX);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], bus.mon_in};
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Arming needs a genuine low sample, so a reset-cleared synchronizer never fakes a rise.
  always_comb begin
    state_nxt = state;
    meas_fire = 1'b0;
    cap_hi    = 1'b0;
    to_fire   = 1'b0;
    unique case (state)
      IDLE: if (vld_pipe[STAGES] && !sync_q[1]) state_nxt = ARM;
      ARM:  if (rise) state_nxt = HIGH;
      HIGH: begin
        if (rise) state_nxt = IDLE;
        else if (fall) begin
          state_nxt = LOW;
          cap_hi    = 1'b1;
        end else if (sat) begin
          state_nxt = IDLE;
          to_fire   = 1'b1;
        end
      end
      LOW: begin
        if (fall) state_nxt = IDLE;
        else if (rise) begin
          state_nxt = HIGH;
          meas_fire = 1'b1;
        end else if (sat) begin
          state_nxt = IDLE;
          to_fire   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt <= '0;
    else if (rise) cnt <= CNT_W'(1);
    else if ((state == HIGH || state == LOW) && !sat) cnt <= cnt + CNT_W'(1);
  end

  // Two spare bits keep 2*high_time and the differences free of overflow.
  always_comb begin
    per_a    = AW'(cnt);
    pdiff    = (per_a >= EXP_A) ? (per_a - EXP_A) : (EXP_A - per_a);
    perr_nxt = (pdiff > TOL_A);
  end

`ifdef DUTY_CHECK_EN
  localparam logic [AW-1:0] TOL2_A = AW'(2 * TOL);
  logic [AW-1:0] h2_a, ddiff;
  always_comb begin
    h2_a     = {1'b0, hi_cap, 1'b0};
    ddiff    = (h2_a >= per_a) ? (h2_a - per_a) : (per_a - h2_a);
    derr_nxt = (ddiff > TOL2_A);
  end
`else
  assign derr_nxt = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hi_cap       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      derr_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= meas_fire;
      if (cap_hi) hi_cap <= cnt;
      if (meas_fire) begin
        period_q  <= cnt;
        high_q    <= hi_cap;
        perr_q    <= perr_nxt;
        derr_q    <= derr_nxt;
        timeout_q <= 1'b0;
      end else if (to_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.period_err = perr_q;
  assign bus.duty_err   = derr_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_clock_period_monitor.sv
// Randomized bench for clock_period_monitor: a 16-bit and a 4-bit instance share one stimulus
// and are checked against a waveform-level model of edges, periods and timeouts.
module tb_clock_period_monitor;
  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int NI  = 2;

  typedef struct {
    int p;
    int h;
    int t;
  } meas_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic mon    = 1'b0;

  clock_period_monitor_if #(.CNT_W(16)) b0 ();
  clock_period_monitor_if #(.CNT_W(4))  b1 ();
  assign b0.mon_in = mon;
  assign b1.mon_in = mon;

  clock_period_monitor #(.CNT_W(16), .EXP_PERIOD(EXP), .TOL(TOL)) u0 (
    .clk_in(clk_in), .rst(rst), .bus(b0));
  clock_period_monitor #(.CNT_W(4), .EXP_PERIOD(EXP), .TOL(TOL)) u1 (
    .clk_in(clk_in), .rst(rst), .bus(b1));

  always #5 clk_in = ~clk_in;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  meas_t q0[$];
  meas_t q1[$];
  bit    armed[NI], have_rise[NI], fall_seen[NI], prev[NI], to_m[NI], last_ok[NI];
  int    rise_t[NI], fall_t[NI], last_vt[NI], last_rt[NI];
  int    maxc[NI] = '{65535, 15};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Waveform-level model: measures rise-to-rise and rise-to-fall distances of the input itself.
  task automatic model_step(input int i, input bit v);
    bit    qual;
    meas_t m;
    qual = 1'b0;
    if (!armed[i]) begin
      if (!v) begin
        armed[i] = 1'b1;
        prev[i]  = 1'b0;
      end
      return;
    end
    if (v && !prev[i]) begin
      if (have_rise[i] && fall_seen[i]) begin
        m.p = cyc - rise_t[i];
        m.h = fall_t[i] - rise_t[i];
        m.t = cyc;
        if (i == 0) q0.push_back(m);
        else        q1.push_back(m);
        to_m[i] = 1'b0;
      end
      have_rise[i] = 1'b1;
      fall_seen[i] = 1'b0;
      rise_t[i]    = cyc;
      qual         = 1'b1;
    end else if (!v && prev[i] && have_rise[i]) begin
      fall_seen[i] = 1'b1;
      fall_t[i]    = cyc;
      qual         = 1'b1;
    end
    prev[i] = v;
    if (have_rise[i] && !qual && (cyc - rise_t[i]) >= maxc[i]) begin
      to_m[i]      = 1'b1;
      armed[i]     = 1'b0;
      have_rise[i] = 1'b0;
      fall_seen[i] = 1'b0;
    end
  endtask

  always @(posedge clk_in) begin
    cyc = cyc + 1;
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < NI; i++) begin
        armed[i] = 1'b0; have_rise[i] = 1'b0; fall_seen[i] = 1'b0;
        prev[i]  = 1'b0; to_m[i] = 1'b0; last_ok[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) model_step(i, mon);
    end
  end

  task automatic mon_check(input int i, input bit vld, input int per, input int hi,
                           input int pe, input int de, input int to);
    meas_t m;
    int    exp_de;
    if (!vld) return;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      chk($sformatf("d%0d_spurious_valid", i), int'(vld), 0);
      return;
    end
    if (i == 0) m = q0.pop_front();
    else        m = q1.pop_front();
`ifdef DUTY_CHECK_EN
    exp_de = (iabs(2 * m.h - m.p) > 2 * TOL) ? 1 : 0;
`else
    exp_de = 0;
`endif
    chk($sformatf("d%0d_period", i), per, m.p);
    chk($sformatf("d%0d_high_time", i), hi, m.h);
    chk($sformatf("d%0d_period_err", i), pe, (iabs(m.p - EXP) > TOL) ? 1 : 0);
    chk($sformatf("d%0d_duty_err", i), de, exp_de);
    chk($sformatf("d%0d_timeout_at_valid", i), to, 0);
    if (last_ok[i]) chk($sformatf("d%0d_valid_spacing", i), cyc - last_vt[i], m.t - last_rt[i]);
    last_ok[i] = 1'b1;
    last_vt[i] = cyc;
    last_rt[i] = m.t;
  endtask

  always @(negedge clk_in) begin
    mon_check(0, b0.meas_valid, int'(b0.period), int'(b0.high_time),
              int'(b0.period_err), int'(b0.duty_err), int'(b0.timeout));
    mon_check(1, b1.meas_valid, int'(b1.period), int'(b1.high_time),
              int'(b1.period_err), int'(b1.duty_err), int'(b1.timeout));
  end

  task automatic check_zero(input string tag);
    chk({tag, "_d0_period"},  int'(b0.period), 0);
    chk({tag, "_d0_high"},    int'(b0.high_time), 0);
    chk({tag, "_d0_valid"},   int'(b0.meas_valid), 0);
    chk({tag, "_d0_perr"},    int'(b0.period_err), 0);
    chk({tag, "_d0_derr"},    int'(b0.duty_err), 0);
    chk({tag, "_d0_timeout"}, int'(b0.timeout), 0);
    chk({tag, "_d1_period"},  int'(b1.period), 0);
    chk({tag, "_d1_high"},    int'(b1.high_time), 0);
    chk({tag, "_d1_valid"},   int'(b1.meas_valid), 0);
    chk({tag, "_d1_perr"},    int'(b1.period_err), 0);
    chk({tag, "_d1_derr"},    int'(b1.duty_err), 0);
    chk({tag, "_d1_timeout"}, int'(b1.timeout), 0);
  endtask

  // All drivers start and end at posedge+#1.
  task automatic hold(input bit v, input int n);
    mon = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic tog(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check_zero(tag);
    rst = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l;
    mon = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk_in);
    #1;

    hold(1'b0, 3);
    tog(5, 5, 6);          // period 10 / high 5
    tog(3, 7, 5);          // duty error case
    tog(7, 7, 4);          // period 14, period error

    // Stuck high: only the 4-bit instance saturates.
    hold(1'b0, 4);
    hold(1'b1, 40);
    @(negedge clk_in);
    chk("d1_timeout_set", int'(b1.timeout), int'(to_m[1]));
    chk("d0_timeout_clear", int'(b0.timeout), int'(to_m[0]));
    @(posedge clk_in);
    #1;
    tog(2, 2, 6);
    hold(1'b0, 3);
    @(negedge clk_in);
    chk("d1_timeout_recovered", int'(b1.timeout), int'(to_m[1]));
    chk("d1_period_after_to", int'(b1.period), 4);
    @(posedge clk_in);
    #1;

    // Reset mid-LOW, then resume.
    tog(5, 5, 3);
    hold(1'b1, 5);
    hold(1'b0, 2);
    pulse_rst("rst_mid_low");
    hold(1'b0, 3);
    tog(5, 5, 4);

    // Input high across reset: first measurement must wait for a fall then a rise.
    mon = 1'b1;
    pulse_rst("rst_mon_high");
    hold(1'b1, 6);
    hold(1'b0, 5);
    tog(5, 5, 4);

    repeat (40) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) h = $urandom_range(14, 20);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(14, 20);
      tog(h, l, 1);
      if ($urandom_range(0, 14) == 0) pulse_rst("rst_rand");
    end

    hold(1'b0, 20);
    @(negedge clk_in);
    chk("d0_pending_meas", q0.size(), 0);
    chk("d1_pending_meas", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
